iob_iobuf_ctrl: RTL and testbench

- Half-duplex sequencer for a DATA_W-bit bidirectional pad bus built from per-bit tri-state buffers (i/oe/o/io).
- Arbitrates between a write requester, which drives the bus, and a read requester, which samples it.
- Inserts turnaround cycles on every direction change so the two ends never drive at the same time.
- Connects between core logic and the pad-level tri-state buffer bank.

---
 rtl/iob_iobuf_ctrl.sv | 163 ++++++++++++++++
 tb/tb_iob_iobuf_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_iobuf_ctrl.sv
// iob_iobuf_ctrl: half-duplex sequencer for a tri-state pad bus.
// A write requester drives the bus and a read requester samples it. Every
// direction change inserts TURN_CYC released-bus cycles so the core side and
// the far end never drive at the same time.
// Optional feature macro: IOB_IOBUF_CTRL_RR_EN
//   defined   -> round-robin between write and read when both contend
//   undefined -> the requester matching the current bus direction wins

module iob_iobuf_ctrl #(
    parameter int DATA_W     = 8,
    parameter int TURN_CYC   = 2,
    parameter int HOLD_CYC   = 1,
    parameter int SAMPLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pad_i,
    output logic              pad_oe,
    input  logic [DATA_W-1:0] pad_o,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        DRIVE  = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_CYC - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic              dir;
    logic              dir_next;
    logic              last_wr;
    logic              last_wr_next;
    logic              rd_valid_next;
    logic [DATA_W-1:0] pad_i_next;
    logic [DATA_W-1:0] rd_data_next;
    logic              win_any;
    logic              win_wr;

    // Pick the requester that would be served if the FSM were idle now.
    // dir=1 means the bus is driven for writes, dir=0 means released for reads.
    always_comb begin
        win_any = wr_valid || rd_req;
        win_wr  = wr_valid;
        if (wr_valid && rd_req) begin
`ifdef IOB_IOBUF_CTRL_RR_EN
            win_wr = !last_wr;
`else
            win_wr = dir;
`endif
        end
    end

    // State and datapath registers; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            dir      <= 1'b0;
            last_wr  <= 1'b0;
            rd_valid <= 1'b0;
            pad_i    <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            dir      <= dir_next;
            last_wr  <= last_wr_next;
            rd_valid <= rd_valid_next;
            pad_i    <= pad_i_next;
            rd_data  <= rd_data_next;
        end
    end

    // Next-state logic plus the handshake and pad-enable outputs.
    // SAMPLE stays one extra cycle while rd_valid is high, so a read occupies
    // the handshake cycle, SAMPLE_CYC sample cycles and the rd_valid cycle.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        dir_next      = dir;
        last_wr_next  = last_wr;
        rd_valid_next = 1'b0;
        pad_i_next    = pad_i;
        rd_data_next  = rd_data;
        wr_ready      = 1'b0;
        rd_ready      = 1'b0;
        pad_oe        = dir && (state != TURN);
        busy          = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (win_any) begin
                    if (win_wr == dir) begin
                        if (win_wr) begin
                            wr_ready     = 1'b1;
                            pad_i_next   = wr_data;
                            cnt_next     = HOLD_LOAD;
                            last_wr_next = 1'b1;
                            state_next   = DRIVE;
                        end else begin
                            rd_ready     = 1'b1;
                            cnt_next     = SAMPLE_LOAD;
                            last_wr_next = 1'b0;
                            state_next   = SAMPLE;
                        end
                    end else begin
                        cnt_next   = TURN_LOAD;
                        state_next = TURN;
                    end
                end
            end

            TURN: begin
                if (cnt == 4'd0) begin
                    dir_next   = !dir;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end

            DRIVE: begin
                if (cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end

            SAMPLE: begin
                if (rd_valid) begin
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    rd_data_next  = pad_o;
                    rd_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_iobuf_ctrl.sv
// Self-checking bench for iob_iobuf_ctrl: a table of per-cycle vectors,
// hand-written multi-cycle sequences and a randomized run against a
// timeline-based reference model. Honours IOB_IOBUF_CTRL_RR_EN.

module tb_iob_iobuf_ctrl;

    localparam int DW     = 8;
    localparam int TURN   = 2;
    localparam int HOLD   = 1;
    localparam int SAMPLE = 2;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pad_i;
    logic          pad_oe;
    logic [DW-1:0] pad_o;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic [DW-1:0] po;
        logic          e_wr_ready;
        logic          e_rd_ready;
        logic          e_pad_oe;
        logic          e_busy;
        logic [DW-1:0] e_pad_i;
        logic          e_rd_valid;
        logic [DW-1:0] e_rd_data;
    } vec_t;

    vec_t tbl[19];

    iob_iobuf_ctrl #(
        .DATA_W     (DW),
        .TURN_CYC   (TURN),
        .HOLD_CYC   (HOLD),
        .SAMPLE_CYC (SAMPLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .pad_i    (pad_i),
        .pad_oe   (pad_oe),
        .pad_o    (pad_o),
        .busy     (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic wv, input logic [DW-1:0] wd,
                                   input logic rr, input logic [DW-1:0] po,
                                   input logic ewr, input logic erd,
                                   input logic eoe, input logic ebusy,
                                   input logic [DW-1:0] epi, input logic erv,
                                   input logic [DW-1:0] erdd);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr; v.po = po;
        v.e_wr_ready = ewr; v.e_rd_ready = erd; v.e_pad_oe = eoe;
        v.e_busy = ebusy; v.e_pad_i = epi; v.e_rd_valid = erv;
        v.e_rd_data = erdd;
        return v;
    endfunction

    task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd,
                                 input logic rr, input logic [DW-1:0] po);
        wr_valid = wv;
        wr_data  = wd;
        rd_req   = rr;
        pad_o    = po;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reset with inputs quiet; returns one time unit after a rising edge.
    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic runTable();
        doReset();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].po);
            @(negedge clk);
            checkOutput($sformatf("row%0d wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_wr_ready));
            checkOutput($sformatf("row%0d rd_ready", i), 32'(rd_ready), 32'(tbl[i].e_rd_ready));
            checkOutput($sformatf("row%0d pad_oe", i), 32'(pad_oe), 32'(tbl[i].e_pad_oe));
            checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            checkOutput($sformatf("row%0d pad_i", i), 32'(pad_i), 32'(tbl[i].e_pad_i));
            checkOutput($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rd_valid));
            checkOutput($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(tbl[i].e_rd_data));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runContention();
        bit grants[6];
        int n_grant = 0;
        int both_seen = 0;
        bit exp_wr;
        doReset();
        applyStimulus(1'b1, 8'h5E, 1'b1, 8'h21);
        for (int c = 0; c < 100 && n_grant < 6; c++) begin
            @(negedge clk);
            if (wr_ready && rd_ready) both_seen++;
            if (wr_ready) begin grants[n_grant] = 1'b1; n_grant++; end
            else if (rd_ready) begin grants[n_grant] = 1'b0; n_grant++; end
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("contention grant count", 32'(n_grant), 32'd6);
        checkOutput("contention never both ready", 32'(both_seen), 32'd0);
        for (int i = 0; i < n_grant; i++) begin
`ifdef IOB_IOBUF_CTRL_RR_EN
            exp_wr = (i % 2 == 0);
`else
            exp_wr = 1'b0;
`endif
            checkOutput($sformatf("contention grant%0d is write", i), 32'(grants[i]), 32'(exp_wr));
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic runResetInDrive();
        bit got = 0;
        doReset();
        applyStimulus(1'b1, 8'hC3, 1'b0, '0);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (wr_ready) got = 1;
            else begin @(posedge clk); #1; end
        end
        checkOutput("drive handshake seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, 1'b0, '0);
        #2;
        checkOutput("drive pad_oe before reset", 32'(pad_oe), 32'd1);
        checkOutput("drive pad_i before reset", 32'(pad_i), 32'hC3);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("async reset pad_i", 32'(pad_i), 32'd0);
        checkOutput("async reset busy drive", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic runResetInSample();
        int rv_count = 0;
        doReset();
        applyStimulus(1'b0, '0, 1'b1, 8'h5A);
        @(negedge clk);
        checkOutput("sample rd_ready", 32'(rd_ready), 32'd1);
        @(posedge clk);
        #1 rd_req = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("sample busy before reset", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("sample reset busy", 32'(busy), 32'd0);
        checkOutput("sample reset pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("sample reset rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rd_valid) rv_count++;
            @(posedge clk);
            #1;
        end
        checkOutput("aborted read rd_valid count", 32'(rv_count), 32'd0);
        checkOutput("aborted read rd_data", 32'(rd_data), 32'd0);
    endtask

    task automatic runFourWrites();
        int hs = 0;
        int turn_cycles = 0;
        int oe_drops = 0;
        int hs_cyc[4];
        doReset();
        applyStimulus(1'b1, 8'h01, 1'b0, '0);
        for (int c = 0; c < 60 && hs < 4; c++) begin
            @(negedge clk);
            if (busy && !pad_oe) turn_cycles++;
            if (hs > 0 && !pad_oe) oe_drops++;
            if (wr_ready) begin hs_cyc[hs] = c; hs++; end
            @(posedge clk);
            #1;
            if (hs == 4) wr_valid = 1'b0;
            else wr_data = 8'(hs + 1);
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        if (!pad_oe) oe_drops++;
        checkOutput("four writes handshakes", 32'(hs), 32'd4);
        checkOutput("four writes turn cycles", 32'(turn_cycles), 32'(TURN));
        checkOutput("four writes pad_oe drops", 32'(oe_drops), 32'd0);
        checkOutput("four writes final pad_i", 32'(pad_i), 32'h04);
        for (int i = 1; i < hs; i++)
            checkOutput($sformatf("write interval%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(HOLD + 1));
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks when the controller becomes free again and the
    // windows in which the bus is turned around or a capture is due.
    task automatic runRandom(input int n_cyc);
        int m_free = 0, m_turn_lo = -10, m_turn_hi = -10, m_cap = -10, m_val = -10;
        bit m_dir = 0, m_last_wr = 0;
        logic [DW-1:0] m_pad_i = '0, m_rd_data = '0;
        bit wv, rr, idle, win_wr, e_wr, e_rd, e_oe;
        logic [DW-1:0] wd, po;
        doReset();
        for (int t = 0; t < n_cyc; t++) begin
            wv = ($urandom_range(0, 99) < 60);
            rr = ($urandom_range(0, 99) < 50);
            wd = DW'($urandom);
            po = DW'($urandom);
            applyStimulus(wv, wd, rr, po);
            idle = (t >= m_free);
            win_wr = wv;
            if (wv && rr) begin
`ifdef IOB_IOBUF_CTRL_RR_EN
                win_wr = !m_last_wr;
`else
                win_wr = m_dir;
`endif
            end
            e_wr = idle && (wv || rr) && (win_wr == m_dir) && win_wr;
            e_rd = idle && (wv || rr) && (win_wr == m_dir) && !win_wr;
            e_oe = m_dir && !(t >= m_turn_lo && t <= m_turn_hi);
            @(negedge clk);
            checkOutput($sformatf("rand t%0d wr_ready", t), 32'(wr_ready), 32'(e_wr));
            checkOutput($sformatf("rand t%0d rd_ready", t), 32'(rd_ready), 32'(e_rd));
            checkOutput($sformatf("rand t%0d pad_oe", t), 32'(pad_oe), 32'(e_oe));
            checkOutput($sformatf("rand t%0d busy", t), 32'(busy), 32'(!idle));
            checkOutput($sformatf("rand t%0d pad_i", t), 32'(pad_i), 32'(m_pad_i));
            checkOutput($sformatf("rand t%0d rd_valid", t), 32'(rd_valid), 32'(t == m_val));
            checkOutput($sformatf("rand t%0d rd_data", t), 32'(rd_data), 32'(m_rd_data));
            if (idle && (wv || rr)) begin
                if (win_wr == m_dir) begin
                    if (win_wr) begin
                        m_pad_i   = wd;
                        m_free    = t + HOLD + 1;
                        m_last_wr = 1;
                    end else begin
                        m_cap     = t + SAMPLE;
                        m_val     = t + SAMPLE + 1;
                        m_free    = t + SAMPLE + 2;
                        m_last_wr = 0;
                    end
                end else begin
                    m_turn_lo = t + 1;
                    m_turn_hi = t + TURN;
                    m_free    = t + TURN + 1;
                end
            end
            if (t == m_cap) m_rd_data = po;
            if (t == m_turn_hi) m_dir = !m_dir;
            @(posedge clk);
            #1;
        end
    endtask

    // Main sequence: reset values, table, corner sequences, random run.
    initial begin
        tbl[0]  = mkVec(0, 8'h00, 1, 8'h3C, 0, 1, 0, 0, 8'h00, 0, 8'h00);
        tbl[1]  = mkVec(0, 8'h00, 0, 8'h3C, 0, 0, 0, 1, 8'h00, 0, 8'h00);
        tbl[2]  = mkVec(0, 8'h00, 0, 8'h3C, 0, 0, 0, 1, 8'h00, 0, 8'h00);
        tbl[3]  = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 8'h3C);
        tbl[4]  = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h3C);
        tbl[5]  = mkVec(1, 8'hA5, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h3C);
        tbl[6]  = mkVec(1, 8'hA5, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h3C);
        tbl[7]  = mkVec(1, 8'hA5, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h3C);
        tbl[8]  = mkVec(1, 8'hA5, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h3C);
        tbl[9]  = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 8'h3C);
        tbl[10] = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 8'h3C);
        tbl[11] = mkVec(0, 8'h00, 1, 8'h77, 0, 0, 1, 0, 8'hA5, 0, 8'h3C);
        tbl[12] = mkVec(0, 8'h00, 1, 8'h77, 0, 0, 0, 1, 8'hA5, 0, 8'h3C);
        tbl[13] = mkVec(0, 8'h00, 1, 8'h77, 0, 0, 0, 1, 8'hA5, 0, 8'h3C);
        tbl[14] = mkVec(0, 8'h00, 1, 8'h77, 0, 1, 0, 0, 8'hA5, 0, 8'h3C);
        tbl[15] = mkVec(0, 8'h00, 0, 8'h77, 0, 0, 0, 1, 8'hA5, 0, 8'h3C);
        tbl[16] = mkVec(0, 8'h00, 0, 8'h77, 0, 0, 0, 1, 8'hA5, 0, 8'h3C);
        tbl[17] = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 8'h77);
        tbl[18] = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 8'h77);

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("reset pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset pad_i", 32'(pad_i), 32'd0);
        checkOutput("reset rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);

        $display("[TB] table vectors");
        runTable();
        $display("[TB] contention sequence");
        runContention();
        $display("[TB] reset during drive");
        runResetInDrive();
        $display("[TB] reset during sample");
        runResetInSample();
        $display("[TB] four back-to-back writes");
        runFourWrites();
        $display("[TB] randomized run");
        runRandom(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
